// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: round-robin arbiter giving a core port and a loader port 3-cycle access to data memory
module dm_access_arbiter #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CReq,
  input  logic [31:0] CAddr,
  input  logic [31:0] CDataWr,
  input  logic        CWr,
  input  logic [2:0]  CCtrl,
  output logic        CGnt,
  output logic        CValid,
  input  logic        LReq,
  input  logic [31:0] LAddr,
  input  logic [31:0] LDataWr,
  input  logic        LWr,
  input  logic [2:0]  LCtrl,
  output logic        LGnt,
  output logic        LValid,
  output logic [31:0] RdData,
  output logic        Err,
  output logic [31:0] DMAddress,
  output logic [31:0] DMDataWr,
  output logic        DMWr,
  output logic [2:0]  DMCtrl,
  input  logic [31:0] DMDataRd,
  output logic        Busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state;
  logic        last_l, win_l, wr_q, err_q;
  logic [31:0] addr_q, data_q;
  logic [2:0]  ctrl_q;
  logic        pick_l, sel_wr, sel_err, ctrl_ok;
  logic [31:0] sel_addr, sel_data;
  logic [2:0]  sel_ctrl, sz;
  logic [32:0] end_addr;
  assign pick_l   = LReq && (!CReq || !last_l);
  assign sel_addr = pick_l ? LAddr : CAddr;
  assign sel_data = pick_l ? LDataWr : CDataWr;
  assign sel_wr   = pick_l ? LWr : CWr;
  assign sel_ctrl = pick_l ? LCtrl : CCtrl;
  assign ctrl_ok  = sel_ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign sz       = sel_ctrl[1:0] == 2'b00 ? 3'd1 : sel_ctrl[1:0] == 2'b01 ? 3'd2 : 3'd4;
  // last byte touched, one bit wider so addresses near 2^32 cannot wrap into range
  assign end_addr = {1'b0, sel_addr} + 33'(sz) - 33'd1;
  assign sel_err  = !ctrl_ok || (sel_wr && sel_ctrl[2]) ||
                    (sel_ctrl[1:0] == 2'b01 && sel_addr[0]) ||
                    (sel_ctrl[1:0] == 2'b10 && sel_addr[1:0] != 2'b00) ||
                    end_addr > 33'(MEM_BYTES - 1);
  assign DMAddress = addr_q;
  assign DMDataWr  = data_q;
  assign DMCtrl    = ctrl_q;
  assign Busy      = state != IDLE;
  // transaction FSM: accept and latch in IDLE, drive memory in ACCESS, respond in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_l <= 1'b1;
      win_l  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      ctrl_q <= '0;
      err_q  <= 1'b0;
      CGnt   <= 1'b0;
      LGnt   <= 1'b0;
      CValid <= 1'b0;
      LValid <= 1'b0;
      DMWr   <= 1'b0;
      RdData <= '0;
      Err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (CReq || LReq) begin
          state  <= ACCESS;
          addr_q <= sel_addr;
          data_q <= sel_data;
          wr_q   <= sel_wr;
          ctrl_q <= sel_ctrl;
          err_q  <= sel_err;
          last_l <= pick_l;
          win_l  <= pick_l;
          CGnt   <= !pick_l;
          LGnt   <= pick_l;
          DMWr   <= sel_wr && !sel_err;
        end
        ACCESS: begin
          state  <= RESP;
          CGnt   <= 1'b0;
          LGnt   <= 1'b0;
          DMWr   <= 1'b0;
          RdData <= (!wr_q && !err_q) ? DMDataRd : 32'd0;
          Err    <= err_q;
          CValid <= !win_l;
          LValid <= win_l;
        end
        RESP: begin
          state  <= IDLE;
          CValid <= 1'b0;
          LValid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: scoreboard bench for the data-memory access arbiter
module tb_dm_access_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        CReq = 0, CWr = 0, LReq = 0, LWr = 0;
  logic [31:0] CAddr = 0, CDataWr = 0, LAddr = 0, LDataWr = 0;
  logic [2:0]  CCtrl = 0, LCtrl = 0;
  logic        CGnt, CValid, LGnt, LValid, Err, DMWr, Busy;
  logic [31:0] RdData, DMAddress, DMDataWr;
  logic [2:0]  DMCtrl;
  logic [31:0] dm_rd = 32'h1234_5678;
  int n_cmp = 0, n_bad = 0;
  typedef struct { bit port; bit err; logic [31:0] rd; } resp_t;
  resp_t sb[$];

  dm_access_arbiter #(.MEM_BYTES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .CReq(CReq), .CAddr(CAddr), .CDataWr(CDataWr), .CWr(CWr), .CCtrl(CCtrl),
    .CGnt(CGnt), .CValid(CValid),
    .LReq(LReq), .LAddr(LAddr), .LDataWr(LDataWr), .LWr(LWr), .LCtrl(LCtrl),
    .LGnt(LGnt), .LValid(LValid),
    .RdData(RdData), .Err(Err), .DMAddress(DMAddress), .DMDataWr(DMDataWr),
    .DMWr(DMWr), .DMCtrl(DMCtrl), .DMDataRd(dm_rd), .Busy(Busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // response monitor: every Valid pops the oldest expected response
  always @(negedge clk) begin
    if (CValid || LValid) begin
      n_cmp++;
      if (CValid && LValid) begin
        n_bad++;
        $display("FAIL valid_overlap: CValid=%0b LValid=%0b, required one-hot", CValid, LValid);
      end else if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: CValid=%0b LValid=%0b with no transaction pending", CValid, LValid);
      end else begin
        resp_t e;
        e = sb.pop_front();
        if (LValid !== e.port || Err !== e.err || RdData !== e.rd) begin
          n_bad++;
          $display("FAIL response: got port=%0b err=%0b rd=%h, required port=%0b err=%0b rd=%h",
                   LValid, Err, RdData, e.port, e.err, e.rd);
        end
      end
    end
  end

  task automatic do_txn(input bit port, input logic [31:0] a, input logic [31:0] d,
                        input bit w, input logic [2:0] c, input bit e, input logic [31:0] rd);
    int n;
    resp_t r;
    @(negedge clk);
    if (port) begin LReq = 1; LAddr = a; LDataWr = d; LWr = w; LCtrl = c; end
    else begin CReq = 1; CAddr = a; CDataWr = d; CWr = w; CCtrl = c; end
    r.port = port; r.err = e; r.rd = rd;
    sb.push_back(r);
    n = 0;
    do begin @(negedge clk); n++; end while (!(port ? LGnt : CGnt) && n < 8);
    n_cmp++;
    if (n != 1 || (port ? CGnt : LGnt) !== 1'b0) begin
      n_bad++;
      $display("FAIL gnt_latency: got %0d cycles CGnt=%0b LGnt=%0b, required 1 cycle port=%0b", n, CGnt, LGnt, port);
    end
    n_cmp++;
    if (DMAddress !== a || DMCtrl !== c || DMWr !== (w && !e) || Busy !== 1'b1 || (w && !e && DMDataWr !== d)) begin
      n_bad++;
      $display("FAIL access: got addr=%h ctrl=%b wr=%0b data=%h busy=%0b, required addr=%h ctrl=%b wr=%0b data=%h",
               DMAddress, DMCtrl, DMWr, DMDataWr, Busy, a, c, w && !e, d);
    end
    CReq = 0; LReq = 0;
    @(negedge clk);
    n_cmp++;
    if (DMWr !== 1'b0 || Busy !== 1'b1 || CGnt !== 1'b0 || LGnt !== 1'b0) begin
      n_bad++;
      $display("FAIL resp_phase: got DMWr=%0b Busy=%0b CGnt=%0b LGnt=%0b, required 0 1 0 0", DMWr, Busy, CGnt, LGnt);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({CGnt, LGnt, CValid, LValid, Err, DMWr, Busy, RdData, DMAddress, DMDataWr, DMCtrl} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b%b valid=%b%b err=%b wr=%b busy=%b rd=%h addr=%h, required all 0",
               CGnt, LGnt, CValid, LValid, Err, DMWr, Busy, RdData, DMAddress);
    end
    rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if (Busy !== 1'b0 || CGnt !== 1'b0 || LGnt !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got Busy=%0b CGnt=%0b LGnt=%0b, required 0", Busy, CGnt, LGnt);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g;
    resp_t r;
    CAddr = 0; CWr = 0; CCtrl = 3'b010; LAddr = 4; LWr = 0; LCtrl = 3'b010;
    CReq = 1; LReq = 1;
    for (int k = 0; k < 4; k++) begin r.port = k[0]; r.err = 0; r.rd = dm_rd; sb.push_back(r); end
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      exp_g = (i % 3 == 1) ? (((i / 3) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++;
      if ({CGnt, LGnt} !== exp_g) begin
        n_bad++;
        $display("FAIL rr_gnt[%0d]: got CGnt,LGnt=%b, required %b", i, {CGnt, LGnt}, exp_g);
      end
    end
    CReq = 0; LReq = 0;
    @(negedge clk);
  endtask

  task automatic test_word_store;
    do_txn(0, 32'd8, 32'hA1B2_C3D4, 1, 3'b010, 0, 32'd0);
  endtask

  task automatic test_misaligned_half;
    do_txn(1, 32'd3, 32'd0, 0, 3'b001, 1, 32'd0);
  endtask

  task automatic test_errors;
    logic [31:0] ta [10] = '{32'd62, 32'd60, 32'd63, 32'd64, 32'hFFFF_FFFF, 32'd62, 32'd0, 32'd0, 32'd2, 32'd6};
    bit          tw [10] = '{1, 1, 0, 0, 0, 1, 0, 1, 0, 0};
    logic [2:0]  tc [10] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b011, 3'b100, 3'b010, 3'b101};
    bit          te [10] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++)
      do_txn(i[0], ta[i], 32'h5A5A_0000 + i, tw[i], tc[i], te[i], (tw[i] || te[i]) ? 32'd0 : dm_rd);
  endtask

  task automatic test_load_unsigned;
    dm_rd = 32'h0000_FF80;
    do_txn(0, 32'd5, 32'd0, 0, 3'b100, 0, 32'h0000_FF80);
  endtask

  task automatic test_reset_abort;
    resp_t r;
    @(negedge clk);
    CReq = 1; CAddr = 12; CDataWr = 32'hDEAD_BEEF; CWr = 1; CCtrl = 3'b010;
    @(negedge clk);
    n_cmp++;
    if (CGnt !== 1'b1 || DMWr !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_setup: got CGnt=%0b DMWr=%0b, required 1 1", CGnt, DMWr);
    end
    CReq = 0; LReq = 1; LAddr = 16; LWr = 0; LCtrl = 3'b010;
    rst_n = 0;
    #1;
    n_cmp++;
    if (DMWr !== 1'b0 || Busy !== 1'b0 || CGnt !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_immediate: got DMWr=%0b Busy=%0b CGnt=%0b, required 0 0 0", DMWr, Busy, CGnt);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (CValid !== 1'b0 || LValid !== 1'b0 || DMWr !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_resp: got CValid=%0b LValid=%0b DMWr=%0b, required 0", CValid, LValid, DMWr);
    end
    rst_n = 1;
    r.port = 1; r.err = 0; r.rd = dm_rd;
    sb.push_back(r);
    @(negedge clk);
    n_cmp++;
    if (LGnt !== 1'b1 || DMAddress !== 32'd16) begin
      n_bad++;
      $display("FAIL abort_pending_l: got LGnt=%0b addr=%h, required 1 00000010", LGnt, DMAddress);
    end
    LReq = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_word_store;
    test_misaligned_half;
    test_errors;
    test_load_unsigned;
    test_reset_abort;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d responses outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dm_access_arbiter.md
DM_ACCESS_ARBITER -- requirements
Module: dm_access_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 64, SHALL be the number of addressable data-memory bytes; legal byte addresses are 0..MEM_BYTES-1.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 CReq  input  1  core request.
REQ-005 CAddr  input  32  core byte address.
REQ-006 CDataWr  input  32  core store data.
REQ-007 CWr  input  1  core store (1) / load (0).
REQ-008 CCtrl  input  3  core access type: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-009 CGnt  output  1  core request accepted.
REQ-010 CValid  output  1  core response valid.
REQ-011 LReq, LAddr, LDataWr, LWr, LCtrl, LGnt, LValid: loader port; SHALL match REQ-004..REQ-010 in direction, width and meaning.
REQ-012 RdData  output  32  load data, shared by both ports, qualified by CValid/LValid.
REQ-013 Err  output  1  access error, qualified by CValid/LValid.
REQ-014 DMAddress  output  32  address driven to data memory.
REQ-015 DMDataWr  output  32  store data driven to data memory.
REQ-016 DMWr  output  1  data-memory write enable.
REQ-017 DMCtrl  output  3  access type driven to data memory.
REQ-018 DMDataRd  input  32  data-memory read data, combinational from DMAddress/DMCtrl.
REQ-019 Busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS when CReq|LReq; ACCESS->RESP always; RESP->IDLE always; one transaction takes exactly 3 cycles.
REQ-021 Req SHALL be sampled only in IDLE; in the IDLE cycle where a request is accepted, the winner's Addr/DataWr/Wr/Ctrl SHALL be latched into internal registers.
REQ-022 Arbitration SHALL be round-robin on a 1-bit last-winner register: single request wins; on simultaneous CReq and LReq the port not granted last wins; last-winner SHALL update on every acceptance.
REQ-023 Winner's Gnt SHALL be high for exactly the ACCESS cycle; loser's Gnt SHALL stay 0 and its request SHALL remain pending.
REQ-024 Requester SHALL hold Req and fields stable until its Gnt and deassert Req by RESP; Req high again in IDLE is a new transaction.
REQ-025 In ACCESS, DMAddress/DMDataWr/DMCtrl SHALL equal the latched fields and DMWr SHALL be latched Wr AND NOT error; in IDLE and RESP, DMWr SHALL be 0 and DMAddress/DMDataWr/DMCtrl SHALL hold the latched values.
REQ-026 Error SHALL be set when Ctrl is not in {000,001,010,100,101}, when Wr=1 with Ctrl 100/101, on half access with Addr[0]=1, on word access with Addr[1:0]!=0, or when Addr+size-1 > MEM_BYTES-1, computed without 32-bit wrap.
REQ-027 At the end of ACCESS, RdData SHALL register DMDataRd for an error-free load and 0 for stores and errors; Err SHALL register the error flag.
REQ-028 Winner's Valid SHALL be high for exactly the RESP cycle; RdData/Err SHALL hold until the next RESP.
REQ-029 A request arriving in ACCESS or RESP SHALL NOT be lost and SHALL be arbitrated in the next IDLE cycle.

Reset
REQ-030 While rst_n=0: state=IDLE, last-winner=L so C wins first tie, all Gnt/Valid/Err/DMWr/Busy=0, RdData/DMAddress/DMDataWr/DMCtrl=0; reset mid-transaction SHALL abort with no write issued after reset asserts.

Verification
REQ-031 Core word store CAddr=8, CDataWr=0xA1B2C3D4, CCtrl=010 -> CGnt cycle 2, DMWr=1 one cycle at DMAddress=8, CValid cycle 3, Err=0, RdData=0.
REQ-032 CReq and LReq both high from reset -> grant order C, L, C, L over four transactions, each 3 cycles, no Gnt overlap.
REQ-033 Loader half load LAddr=3, LCtrl=001 -> DMWr never 1, LValid with Err=1, RdData=0.
REQ-034 Core word store CAddr=62, CCtrl=010 -> range error, DMWr stays 0, Err=1; CAddr=60 -> accepted, Err=0.
REQ-035 Core load with DMDataRd=0x0000FF80, CCtrl=100 -> RdData=0x0000FF80 captured at end of ACCESS, CValid in RESP.
REQ-036 rst_n low during ACCESS of a store -> DMWr=0 immediately, state IDLE, no Valid; after release, pending LReq granted next cycle.
